cursor_tracker: RTL and testbench

CURSOR_TRACKER -- requirements
Module: cursor_tracker

---
 rtl/cursor_tracker.sv | 138 +++++++++++++
 tb/tb_cursor_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_tracker.sv
// Cursor position tracker: synchronises a mouse packet strobe and applies clamped X/Y moves.
// Optional CURSOR_ACCEL_EN doubles magnitudes of 32 or more before they are applied.
module cursor_tracker #(
  parameter int H_MAX  = 639,
  parameter int V_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Pkt_Strobe,
  input  logic       Izquierda,
  input  logic       Abajo,
  input  logic [7:0] MagX,
  input  logic [7:0] MagY,
  input  logic       Click,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic       Upd_Valid,
  output logic       Click_Pulse,
  output logic       Pkt_Drop
);

  typedef enum logic [2:0] {IDLE, CAPTURE, CALC, CLAMP, COMMIT} state_t;

  localparam logic signed [11:0] X_LIM = 12'(H_MAX);
  localparam logic signed [11:0] Y_LIM = 12'(V_MAX);

  state_t state, state_nxt;

  logic sync1, sync2, sync3;
  logic filled, armed;
  logic strobe_edge;

  logic       cap_left, cap_down, cap_click, prev_click;
  logic [7:0] cap_mx, cap_my;
  logic [8:0] eff_mx, eff_my;
  logic signed [11:0] tgt_x, tgt_y;
  logic [9:0] clp_x, clp_y;

  // Edges only count once a genuine low has been sampled after reset, so a strobe
  // still high when reset is released is not mistaken for a new packet.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      filled <= 1'b0;
      armed  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1  <= Pkt_Strobe;
      sync2  <= sync1;
      sync3  <= sync2;
      filled <= 1'b1;
      if (filled && !sync1) armed <= 1'b1;
    end
  end

  assign strobe_edge = sync2 & ~sync3 & armed;
  assign Pkt_Drop    = strobe_edge & (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (strobe_edge) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CALC;
      CALC:    state_nxt = CLAMP;
      CLAMP:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CURSOR_ACCEL_EN
  assign eff_mx = (cap_mx >= 8'd32) ? {cap_mx, 1'b0} : {1'b0, cap_mx};
  assign eff_my = (cap_my >= 8'd32) ? {cap_my, 1'b0} : {1'b0, cap_my};
`else
  assign eff_mx = {1'b0, cap_mx};
  assign eff_my = {1'b0, cap_my};
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PosX        <= 10'(X_INIT);
      PosY        <= 10'(Y_INIT);
      Upd_Valid   <= 1'b0;
      Click_Pulse <= 1'b0;
      cap_left    <= 1'b0;
      cap_down    <= 1'b0;
      cap_click   <= 1'b0;
      prev_click  <= 1'b0;
      cap_mx      <= '0;
      cap_my      <= '0;
      tgt_x       <= '0;
      tgt_y       <= '0;
      clp_x       <= '0;
      clp_y       <= '0;
    end else begin
      Upd_Valid   <= 1'b0;
      Click_Pulse <= 1'b0;
      case (state)
        CAPTURE: begin
          cap_left  <= Izquierda;
          cap_down  <= Abajo;
          cap_mx    <= MagX;
          cap_my    <= MagY;
          cap_click <= Click;
        end
        CALC: begin
          tgt_x <= cap_left ? $signed({2'b00, PosX}) - $signed({3'b000, eff_mx})
                            : $signed({2'b00, PosX}) + $signed({3'b000, eff_mx});
          tgt_y <= cap_down ? $signed({2'b00, PosY}) + $signed({3'b000, eff_my})
                            : $signed({2'b00, PosY}) - $signed({3'b000, eff_my});
        end
        CLAMP: begin
          clp_x <= tgt_x[11] ? '0 : (tgt_x > X_LIM) ? 10'(H_MAX) : tgt_x[9:0];
          clp_y <= tgt_y[11] ? '0 : (tgt_y > Y_LIM) ? 10'(V_MAX) : tgt_y[9:0];
        end
        COMMIT: begin
          PosX        <= clp_x;
          PosY        <= clp_y;
          Upd_Valid   <= 1'b1;
          Click_Pulse <= cap_click & ~prev_click;
          prev_click  <= cap_click;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_tracker.sv
// Self-checking bench for cursor_tracker: packet-level reference model plus directed and random packets.
module tb_cursor_tracker;
  localparam int H_MAX = 639, V_MAX = 479, X_INIT = 320, Y_INIT = 240;

  logic clk = 1'b0, rst_n = 1'b1;
  logic strobe = 1'b0, left = 1'b0, down = 1'b0, click = 1'b0;
  logic [7:0] mx = '0, my = '0;
  logic [9:0] pos_x, pos_y;
  logic upd, cpulse, drop;

  always #5 clk = ~clk;

  cursor_tracker dut (
    .Clk(clk), .Rst_n(rst_n), .Pkt_Strobe(strobe), .Izquierda(left), .Abajo(down),
    .MagX(mx), .MagY(my), .Click(click), .PosX(pos_x), .PosY(pos_y),
    .Upd_Valid(upd), .Click_Pulse(cpulse), .Pkt_Drop(drop)
  );

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is accepted on a sampled 0->1 strobe transition
  // (after reset) unless a previous packet is still in flight. Its inputs are
  // taken 3 edges after the first high sample and the move lands 6 edges after.
  typedef struct {int t0; bit l; bit a; bit c; int mx; int my;} pkt_t;
  pkt_t q[$];
  pkt_t np;
  int  cyc = 0, last_t0 = 0;
  bit  has_prev = 0, prev_s = 0, last_valid = 0;
  int  m_x = X_INIT, m_y = Y_INIT;
  bit  m_prev_click = 0;
  bit  e_upd = 0, e_click = 0, e_drop = 0, drop_next = 0;

  function automatic int move(input int pos, input int mag, input bit neg, input int lim);
    int p;
`ifdef CURSOR_ACCEL_EN
    if (mag >= 32) mag = mag * 2;
`endif
    p = neg ? pos - mag : pos + mag;
    if (p < 0)   p = 0;
    if (p > lim) p = lim;
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; has_prev = 0; prev_s = 0; last_valid = 0; q.delete();
      m_x = X_INIT; m_y = Y_INIT; m_prev_click = 0;
      e_upd = 0; e_click = 0; e_drop = 0; drop_next = 0;
    end else begin
      cyc++;
      e_upd = 0; e_click = 0; e_drop = drop_next; drop_next = 0;
      for (int i = 0; i < q.size(); i++)
        if (cyc == q[i].t0 + 3) begin
          q[i].l = left; q[i].a = down; q[i].c = click; q[i].mx = mx; q[i].my = my;
        end
      if (q.size() > 0 && cyc == q[0].t0 + 6) begin
        m_x = move(m_x, q[0].mx, q[0].l, H_MAX);
        m_y = move(m_y, q[0].my, !q[0].a, V_MAX);
        e_upd = 1;
        e_click = q[0].c && !m_prev_click;
        m_prev_click = q[0].c;
        void'(q.pop_front());
      end
      if (has_prev && !prev_s && strobe) begin
        if (last_valid && cyc - last_t0 >= 1 && cyc - last_t0 <= 4) drop_next = 1;
        else begin
          np = '{t0: cyc, l: 0, a: 0, c: 0, mx: 0, my: 0};
          q.push_back(np);
          last_valid = 1; last_t0 = cyc;
        end
      end
      prev_s = strobe; has_prev = 1;
    end
  end

  int drops_seen = 0, upd_seen = 0, clicks_seen = 0;

  always @(negedge clk) begin
    check("pos_x", pos_x, m_x);
    check("pos_y", pos_y, m_y);
    check("upd_valid", upd, e_upd);
    check("click_pulse", cpulse, e_click);
    check("pkt_drop", drop, e_drop);
    if (drop === 1'b1)   drops_seen++;
    if (upd === 1'b1)    upd_seen++;
    if (cpulse === 1'b1) clicks_seen++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send(input bit l, input bit a, input int x, input int y, input bit c, input int hi);
    tick(1);
    left = l; down = a; mx = 8'(x); my = 8'(y); click = c; strobe = 1'b1;
    tick(hi);
    strobe = 1'b0;
  endtask

  task automatic do_reset();
    tick(1); rst_n = 1'b0;
    tick(2); rst_n = 1'b1;
    tick(2);
  endtask

  int d0, u0, c0;
  logic [4:0] pattern;
  bit [4:0] clk_seq;

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    check("reset_pos_x", pos_x, 320);
    check("reset_pos_y", pos_y, 240);
    check("reset_upd", upd, 0);
    check("reset_drop", drop, 0);
    rst_n = 1'b1;
    tick(3);

    // First packet: right 10, down 5; update visible 6 edges after first sample.
    send(0, 1, 10, 5, 0, 3);
    tick(3);
    check("lat_upd_early", upd, 0);
    check("lat_pos_x_early", pos_x, 320);
    tick(1);
    check("lat_upd", upd, 1);
    check("pkt1_pos_x", pos_x, 330);
    check("pkt1_pos_y", pos_y, 245);
    tick(3);

    // Left edge clamp from X=5, bottom clamp from Y=470.
    send(1, 1, 255, 255, 0, 3); tick(6);
    send(1, 1, 255, 255, 0, 3); tick(6);
    check("left_floor", pos_x, 0);
    check("bottom_ceiling", pos_y, 479);
    send(0, 0, 5, 9, 0, 3); tick(6);
    check("x_at_5", pos_x, 5);
    check("y_at_470", pos_y, 470);
    send(1, 1, 20, 200, 0, 3); tick(6);
    check("x_clamp_0", pos_x, 0);
    check("y_clamp_479", pos_y, 479);

    // Overlapping strobe: second edge lands while the first packet is in flight.
    d0 = drops_seen; u0 = upd_seen;
    tick(1);
    left = 0; down = 0; mx = 8'd20; my = 8'd10; click = 0; strobe = 1'b1;
    tick(3); strobe = 1'b0;
    tick(1); strobe = 1'b1;
    tick(3); strobe = 1'b0;
    tick(8);
    check("drop_count", drops_seen - d0, 1);
    check("overlap_upd_count", upd_seen - u0, 1);
    check("overlap_pos_x", pos_x, 20);
    check("overlap_pos_y", pos_y, 469);

    // Click history 0,1,1,0,1 with zero-magnitude packets.
    clk_seq = 5'b10110;
    pattern = '0;
    u0 = upd_seen;
    for (int i = 0; i < 5; i++) begin
      c0 = clicks_seen;
      send(0, 0, 0, 0, clk_seq[i], 3);
      tick(6);
      pattern[i] = (clicks_seen != c0);
    end
    check("click_pattern", pattern, 5'b10010);
    check("zero_mag_upd_count", upd_seen - u0, 5);
    check("zero_mag_pos_x", pos_x, 20);
    check("zero_mag_pos_y", pos_y, 469);

    // Reset during CALC with the strobe still high.
    tick(1);
    left = 0; down = 1; mx = 8'd100; my = 8'd100; click = 0; strobe = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    u0 = upd_seen;
    tick(10);
    check("rst_mid_pos_x", pos_x, 320);
    check("rst_mid_pos_y", pos_y, 240);
    check("rst_mid_no_upd", upd_seen - u0, 0);
    strobe = 1'b0;
    tick(2);
    send(0, 1, 1, 1, 0, 3); tick(6);
    check("post_rst_pos_x", pos_x, 321);
    check("post_rst_pos_y", pos_y, 241);

    // Acceleration threshold at 32.
    do_reset();
    send(0, 0, 40, 0, 0, 3); tick(6);
`ifdef CURSOR_ACCEL_EN
    check("accel_40", pos_x, 400);
`else
    check("plain_40", pos_x, 360);
`endif
    send(0, 0, 31, 0, 0, 3); tick(6);
`ifdef CURSOR_ACCEL_EN
    check("accel_31", pos_x, 431);
`else
    check("plain_31", pos_x, 391);
`endif

    // Random packets, with short gaps that sometimes overlap an in-flight packet.
    for (int i = 0; i < 80; i++) begin
      send(1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)),
           1'($urandom), int'($urandom_range(3, 5)));
      tick(int'($urandom_range(1, 8)));
    end
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
